cache_rd_arbiter: RTL and testbench
===================================

Name: cache_rd_arbiter

Overview:
- Two-to-one read arbiter between the ICache and DCache refill/read ports and the single read port of the AXI bridge.
- Serialises requests with one transaction outstanding at a time and routes return beats back to the owning cache.
- Blocks a DCache read that hits a line still being written back.
- Uses DCache-first priority with a starvation guard for the ICache, and flags return-beat count errors.

Parameters:
- STARVE_LIMIT, 8, consecutive DCache grants while ICache is waiting; reaching this forces the next grant to ICache (range 1..15).

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_rd_req  in  1  ICache read request
- ic_rd_type  in  3  3'b100 = 4-beat line, 3'b010 = single word
- ic_rd_addr  in  32  ICache read address
- ic_rd_rdy  out  1  ICache request accepted this cycle
- ic_ret_valid  out  1  return beat valid to ICache
- ic_ret_last  out  1  last return beat to ICache
- ic_ret_data  out  32  return data to ICache
- dc_rd_req, dc_rd_type, dc_rd_addr, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data  same widths and meanings, DCache side
- wb_busy  in  1  bridge write path holds an unfinished write
- wb_addr  in  32  address of that write
- mem_rd_req  out  1  request to bridge
- mem_rd_type  out  3  latched request type
- mem_rd_addr  out  32  latched request address
- mem_rd_rdy  in  1  bridge accepts the request
- mem_ret_valid  in  1  return beat from bridge
- mem_ret_last  in  1  last return beat from bridge
- mem_ret_data  in  32  return data from bridge
- protocol_err  out  1  sticky beat-count error flag

Behaviour:
- States: IDLE, REQ, RESP (one-hot).
- Reset (synchronous, reset=1):
  - state=IDLE; all rdy, ret_valid and ret_last outputs = 0; mem_rd_req = 0.
  - mem_rd_type=0, mem_rd_addr=0; owner=0 (0 = ICache, 1 = DCache).
  - starve_cnt=0, beat_cnt=0, protocol_err=0.
  - Reset mid-transaction abandons it. Any beats arriving after reset deasserts are ignored: they are not routed and do not set protocol_err.
- Hazard: dc_blk = wb_busy & (wb_addr[31:4] == dc_rd_addr[31:4]).
- Eligibility: dc_ok = dc_rd_req & ~dc_blk; ic_ok = ic_rd_req.
- IDLE arbitration (combinational):
  - If starve_cnt == STARVE_LIMIT and ic_ok: ICache wins.
  - Otherwise if dc_ok: DCache wins.
  - Otherwise if ic_ok: ICache wins.
  - Exactly one rdy is asserted, to the winner only, and only in IDLE. rdy never asserts in REQ or RESP.
- On a grant (req & rdy):
  - Latch type, addr and owner; go to REQ next cycle.
  - mem_rd_req rises one cycle after the grant.
- starve_cnt update, on each grant:
  - DCache granted while ic_rd_req = 1: increment, saturating at STARVE_LIMIT.
  - ICache granted: clear to 0.
  - Otherwise: hold.
- REQ:
  - mem_rd_req = 1 with stable mem_rd_type and mem_rd_addr.
  - On mem_rd_rdy: go to RESP and clear beat_cnt. Otherwise stay.
- RESP:
  - Route mem_ret_valid, mem_ret_last and mem_ret_data combinationally (zero cycles) to the owner's ret_* outputs.
  - The non-owner's ret_valid and ret_last stay 0. ret_data goes to both sides unchanged.
  - beat_cnt increments on each mem_ret_valid.
  - On mem_ret_valid & mem_ret_last: go to IDLE. A new grant is possible in the cycle after last.
- Beat check: protocol_err is set (sticky until reset) when either:
  - mem_ret_last arrives on beat index ≠ 3 for a line request, or ≠ 0 for a word request; or
  - a fourth line beat (index 3) arrives without mem_ret_last. The FSM then stays in RESP until last.
- mem_ret_valid in IDLE or REQ: ignored, not routed, sets protocol_err.
- dc_blk changing while DCache is waiting: re-evaluated every IDLE cycle, no latching.
- Both requests arriving in the same cycle as a return last beat: arbitration happens in the following IDLE cycle.
- Latency:
  - Grant to mem_rd_req: 1 cycle.
  - mem_rd_rdy to return: bridge-determined.
  - Return to cache: 0 cycles.

Test Plan:
- ICache only: ic_rd_req=1, type=3'b100, addr=0x1C000040 → ic_rd_rdy=1 in cycle 0; mem_rd_req=1 with addr 0x1C000040 and type 3'b100 in cycle 1; after rdy, 4 beats 0xA0..0xA3 appear on ic_ret_data with ic_ret_last on 0xA3; dc_ret_valid stays 0.
- Simultaneous requests, starve_cnt=0 → DCache granted first. ICache granted after DCache ret_last. starve_cnt returns to 0.
- DCache held high, ICache held high, STARVE_LIMIT=2 → grant order D, D, I, D, D, I.
- wb_busy=1, wb_addr=0x00001234, dc_rd_addr=0x00001238, ICache idle → no grant. Drop wb_busy → dc_rd_rdy=1 next IDLE cycle. Same test with dc_rd_addr=0x00001244 → immediate grant.
- Line request, bridge asserts mem_ret_last on beat 2 → protocol_err=1, FSM returns to IDLE. protocol_err stays 1 through later good transactions until reset.
- Reset asserted in RESP after 2 beats → next cycle mem_rd_req=0, state IDLE. The remaining 2 beats are not routed and protocol_err stays 0.

Source files
------------

// File: rtl/cache_rd_arbiter.sv
// Two-to-one ICache/DCache read arbiter onto a single bridge read port, one transaction outstanding.
// Latency: grant to mem_rd_req 1 cycle, return beats routed to the owner combinationally.
// Backpressure: rdy only in IDLE; DCache blocked on write-back address hazard; bridge holds REQ until mem_rd_rdy.
module cache_rd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    output logic [31:0] ic_ret_data,
    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] dc_ret_data,
    input  logic        wb_busy,
    input  logic [31:0] wb_addr,
    output logic        mem_rd_req,
    output logic [2:0]  mem_rd_type,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_rdy,
    input  logic        mem_ret_valid,
    input  logic        mem_ret_last,
    input  logic [31:0] mem_ret_data,
    output logic        protocol_err
);
    localparam logic [2:0] TYPE_LINE  = 3'b100;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q;
    logic [3:0]  starve_cnt;
    logic [2:0]  beat_cnt;
    logic        drain_q;
    logic        dc_blk, dc_ok, ic_ok, arb_en, grant_ic, grant_dc;
    logic        in_resp, ret_beat, ret_end, line_req, beat_err, stray_beat, in_flight;
    logic        unused_ok;

    // Only the line index takes part in the write-back hazard compare.
    assign unused_ok = ^{wb_addr[3:0], dc_rd_addr[3:0]};

    always_comb begin
        dc_blk    = wb_busy & (wb_addr[31:4] == dc_rd_addr[31:4]);
        dc_ok     = dc_rd_req & ~dc_blk;
        ic_ok     = ic_rd_req;
        // drain_q: a transaction was abandoned by reset and its beats are still arriving.
        arb_en    = (state_q == IDLE) & ~reset & ~drain_q;
        grant_ic  = arb_en & ic_ok & ((starve_cnt == STARVE_MAX) | ~dc_ok);
        grant_dc  = arb_en & dc_ok & ~grant_ic;
        in_resp   = (state_q == RESP) & ~reset;
        ret_beat  = in_resp & mem_ret_valid;
        ret_end   = ret_beat & mem_ret_last;
        line_req  = (mem_rd_type == TYPE_LINE);
        if (mem_ret_last) begin
            beat_err = ret_beat & (beat_cnt != (line_req ? 3'd3 : 3'd0));
        end else begin
            beat_err = ret_beat & line_req & (beat_cnt == 3'd3);
        end
        stray_beat = mem_ret_valid & ~drain_q & (state_q != RESP);
        in_flight  = (state_q == RESP) | ((state_q == REQ) & mem_rd_rdy);
    end

    assign ic_rd_rdy    = grant_ic;
    assign dc_rd_rdy    = grant_dc;
    assign mem_rd_req   = (state_q == REQ);
    assign ic_ret_valid = ret_beat & ~owner_q;
    assign ic_ret_last  = ret_end & ~owner_q;
    assign dc_ret_valid = ret_beat & owner_q;
    assign dc_ret_last  = ret_end & owner_q;
    assign ic_ret_data  = mem_ret_data;
    assign dc_ret_data  = mem_ret_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_ic | grant_dc) state_d = REQ;
            REQ:     if (mem_rd_rdy) state_d = RESP;
            RESP:    if (mem_ret_valid & mem_ret_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            mem_rd_type  <= 3'd0;
            mem_rd_addr  <= 32'd0;
            starve_cnt   <= 4'd0;
            beat_cnt     <= 3'd0;
            protocol_err <= 1'b0;
            drain_q      <= (drain_q | in_flight) & ~(mem_ret_valid & mem_ret_last);
        end else begin
            state_q <= state_d;
            if (grant_ic | grant_dc) begin
                owner_q     <= grant_dc;
                mem_rd_type <= grant_dc ? dc_rd_type : ic_rd_type;
                mem_rd_addr <= grant_dc ? dc_rd_addr : ic_rd_addr;
            end
            if (grant_ic) begin
                starve_cnt <= 4'd0;
            end else if (grant_dc & ic_rd_req & (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            // Saturate so an overlong burst cannot wrap back onto a legal index.
            if ((state_q == REQ) & mem_rd_rdy) begin
                beat_cnt <= 3'd0;
            end else if (ret_beat & (beat_cnt != 3'd7)) begin
                beat_cnt <= beat_cnt + 3'd1;
            end
            if (beat_err | stray_beat) protocol_err <= 1'b1;
            if (drain_q & mem_ret_valid & mem_ret_last) drain_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Randomized and directed bench for cache_rd_arbiter against a transaction-level reference model.
module tb_cache_rd_arbiter;
    localparam int LIM = 2;
    localparam int P_IDLE = 0, P_REQ = 1, P_RESP = 2;

    logic        aclk = 1'b0;
    logic        reset;
    logic        ic_rd_req, dc_rd_req;
    logic [2:0]  ic_rd_type, dc_rd_type;
    logic [31:0] ic_rd_addr, dc_rd_addr;
    logic        ic_rd_rdy, dc_rd_rdy;
    logic        ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
    logic [31:0] ic_ret_data, dc_ret_data;
    logic        wb_busy;
    logic [31:0] wb_addr;
    logic        mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
    logic [2:0]  mem_rd_type;
    logic [31:0] mem_rd_addr, mem_ret_data;
    logic        protocol_err;

    cache_rd_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .aclk(aclk), .reset(reset),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .wb_busy(wb_busy), .wb_addr(wb_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
        .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
        .protocol_err(protocol_err)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0, n_bad = 0;
    bit chk_en = 0;

    // reference model: one outstanding transaction, tracked at transaction level
    int          m_phase = P_IDLE;
    bit          m_owner = 0, m_err = 0, m_drain = 0;
    int          m_starve = 0, m_beats = 0;
    logic [2:0]  m_type = 3'd0;
    logic [31:0] m_addr = 32'd0;
    bit          e_ic, e_dc;

    // observations
    bit          last_ic_rdy, last_dc_rdy;
    int          dut_grants[$];
    logic [31:0] ic_seen[$];
    logic [31:0] ic_last_data;
    int          dc_seen_n;

    // bridge stimulus
    bit          br_send = 0, br_gaps = 0, br_rand = 0, br_stray = 0;
    int          br_beat = 0, br_last_at = 0, br_force = -1;
    logic [31:0] br_base = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit dc_ok_e, route;
        dc_ok_e = dc_rd_req && !(wb_busy && ((wb_addr >> 4) == (dc_rd_addr >> 4)));
        e_ic = 0;
        e_dc = 0;
        if (m_phase == P_IDLE && !reset && !m_drain) begin
            if (ic_rd_req && m_starve == LIM) e_ic = 1;
            else if (dc_ok_e)                 e_dc = 1;
            else if (ic_rd_req)               e_ic = 1;
        end
        route = (m_phase == P_RESP) && !reset && mem_ret_valid;
        if (chk_en) begin
            chk("ic_rdy", ic_rd_rdy, e_ic);
            chk("dc_rdy", dc_rd_rdy, e_dc);
            chk("mem_req", mem_rd_req, m_phase == P_REQ);
            chk("mem_type", mem_rd_type, m_type);
            chk("mem_addr", mem_rd_addr, m_addr);
            chk("ic_vld", ic_ret_valid, route && !m_owner);
            chk("ic_last", ic_ret_last, route && mem_ret_last && !m_owner);
            chk("dc_vld", dc_ret_valid, route && m_owner);
            chk("dc_last", dc_ret_last, route && mem_ret_last && m_owner);
            chk("ic_data", ic_ret_data, mem_ret_data);
            chk("dc_data", dc_ret_data, mem_ret_data);
            chk("perr", protocol_err, m_err);
        end
        last_ic_rdy = ic_rd_rdy;
        last_dc_rdy = dc_rd_rdy;
        if (ic_rd_rdy) dut_grants.push_back(0);
        if (dc_rd_rdy) dut_grants.push_back(1);
        if (ic_ret_valid) ic_seen.push_back(ic_ret_data);
        if (ic_ret_valid && ic_ret_last) ic_last_data = ic_ret_data;
        if (dc_ret_valid) dc_seen_n++;
    endtask

    task automatic model_step();
        bit line;
        if (reset) begin
            m_drain  = (m_drain || m_phase == P_RESP || (m_phase == P_REQ && mem_rd_rdy))
                       && !(mem_ret_valid && mem_ret_last);
            m_phase  = P_IDLE;
            m_owner  = 0;
            m_starve = 0;
            m_type   = 3'd0;
            m_addr   = 32'd0;
            m_beats  = 0;
            m_err    = 0;
        end else begin
            if (mem_ret_valid && m_phase != P_RESP) begin
                if (!m_drain) m_err = 1;
                else if (mem_ret_last) m_drain = 0;
            end
            case (m_phase)
                P_IDLE: if (e_ic || e_dc) begin
                    m_phase = P_REQ;
                    m_owner = e_dc;
                    m_type  = e_dc ? dc_rd_type : ic_rd_type;
                    m_addr  = e_dc ? dc_rd_addr : ic_rd_addr;
                    if (e_ic) m_starve = 0;
                    else if (ic_rd_req && m_starve < LIM) m_starve++;
                end
                P_REQ: if (mem_rd_rdy) begin
                    m_phase = P_RESP;
                    m_beats = 0;
                end
                default: if (mem_ret_valid) begin
                    line = (m_type == 3'b100);
                    if (mem_ret_last && m_beats != (line ? 3 : 0)) m_err = 1;
                    if (!mem_ret_last && line && m_beats == 3) m_err = 1;
                    m_beats++;
                    if (mem_ret_last) m_phase = P_IDLE;
                end
            endcase
        end
    endtask

    task automatic tick();
        bit d_rdy, d_vld, d_last;
        d_rdy = 0; d_vld = 0; d_last = 0;
        if (br_send) begin
            if (!br_gaps || $urandom_range(0, 3) != 0) begin
                d_vld  = 1;
                d_last = (br_beat == br_last_at);
            end
        end else if (m_phase == P_REQ) begin
            d_rdy = !br_rand || ($urandom_range(0, 2) == 0);
        end
        if (br_stray) d_vld = 1;
        mem_rd_rdy    = d_rdy;
        mem_ret_valid = d_vld;
        mem_ret_last  = d_last;
        mem_ret_data  = d_vld ? br_base + 32'(br_beat) : $urandom;
        if (d_rdy) br_last_at = (br_force >= 0) ? br_force : ((m_type == 3'b100) ? 3 : 0);
        @(negedge aclk);
        check_outputs();
        model_step();
        @(posedge aclk);
        #1;
        if (d_rdy) begin
            br_send = 1;
            br_beat = 0;
        end else if (d_vld && br_send) begin
            if (d_last) br_send = 0;
            else br_beat++;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((m_phase != P_IDLE || br_send || m_drain) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, n < 200, 1);
    endtask

    task automatic run_line(input bit dc, input int force_last, input string tag);
        int n = 0;
        br_force = force_last;
        if (dc) begin
            dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_5000;
        end else begin
            ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_6000;
        end
        tick();
        while (!(dc ? last_dc_rdy : last_ic_rdy) && n < 50) begin
            tick();
            n++;
        end
        ic_rd_req = 0;
        dc_rd_req = 0;
        wait_idle(tag);
        br_force = -1;
    endtask

    initial begin
        int n;
        int exp_order[6] = '{1, 1, 0, 1, 1, 0};
        reset = 1;
        ic_rd_req = 0; ic_rd_type = 3'd0; ic_rd_addr = 32'd0;
        dc_rd_req = 0; dc_rd_type = 3'd0; dc_rd_addr = 32'd0;
        wb_busy = 0; wb_addr = 32'd0;
        mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 32'd0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_mem_req", mem_rd_req, 0);
        chk("rst_perr", protocol_err, 0);
        reset = 0;

        // ICache-only line fill
        ic_seen.delete(); dc_seen_n = 0; ic_last_data = 32'd0;
        br_base = 32'hA0;
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040;
        tick();
        chk("t1_ic_rdy", last_ic_rdy, 1);
        ic_rd_req = 0;
        chk("t1_mem_req", mem_rd_req, 1);
        chk("t1_mem_addr", mem_rd_addr, 32'h1C00_0040);
        chk("t1_mem_type", mem_rd_type, 3'b100);
        wait_idle("t1");
        chk("t1_beats", ic_seen.size(), 4);
        if (ic_seen.size() == 4) chk("t1_first", ic_seen[0], 32'hA0);
        chk("t1_last_data", ic_last_data, 32'hA3);
        chk("t1_dc_beats", dc_seen_n, 0);

        // simultaneous requests: DCache first, then ICache
        do_reset();
        dut_grants.delete();
        ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_1000;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_2000;
        tick();
        chk("t2_dc_first", last_dc_rdy, 1);
        dc_rd_req = 0;
        n = 0;
        while (!last_ic_rdy && n < 50) begin tick(); n++; end
        chk("t2_ic_next", last_ic_rdy, 1);
        ic_rd_req = 0;
        wait_idle("t2");
        chk("t2_order", dut_grants.size() == 2 && dut_grants[0] == 1 && dut_grants[1] == 0, 1);

        // starvation guard with both sides held high
        do_reset();
        dut_grants.delete();
        ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_3000;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_4000;
        n = 0;
        while (dut_grants.size() < 6 && n < 300) begin tick(); n++; end
        ic_rd_req = 0; dc_rd_req = 0;
        wait_idle("t3");
        chk("t3_count", dut_grants.size() >= 6, 1);
        for (int i = 0; i < 6; i++)
            if (i < dut_grants.size()) chk($sformatf("t3_grant%0d", i), dut_grants[i], exp_order[i]);

        // write-back hazard
        do_reset();
        wb_busy = 1; wb_addr = 32'h0000_1234;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_1238;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_blocked", last_dc_rdy, 0);
        end
        wb_busy = 0;
        tick();
        chk("t4_released", last_dc_rdy, 1);
        dc_rd_req = 0;
        wait_idle("t4a");
        wb_busy = 1;
        dc_rd_req = 1; dc_rd_addr = 32'h0000_1244;
        tick();
        chk("t4_other_line", last_dc_rdy, 1);
        dc_rd_req = 0; wb_busy = 0;
        wait_idle("t4b");

        // early last is sticky until reset
        do_reset();
        run_line(0, 2, "t5a");
        chk("t5_early_last", protocol_err, 1);
        chk("t5_idle", mem_rd_req, 0);
        run_line(1, -1, "t5b");
        chk("t5_sticky", protocol_err, 1);
        do_reset();
        chk("t5_cleared", protocol_err, 0);
        run_line(1, 4, "t5c");
        chk("t5_late_last", protocol_err, 1);
        do_reset();
        br_stray = 1;
        tick();
        br_stray = 0;
        chk("t5_stray", protocol_err, 1);
        do_reset();
        br_force = 1;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_7000;
        tick();
        dc_rd_req = 0;
        wait_idle("t5d");
        br_force = -1;
        chk("t5_word_len", protocol_err, 1);

        // reset in the middle of a response
        do_reset();
        ic_seen.delete();
        br_base = 32'hC0;
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_8000;
        n = 0;
        while (ic_seen.size() < 2 && n < 50) begin
            tick();
            if (last_ic_rdy) ic_rd_req = 0;
            n++;
        end
        chk("t6_two_beats", ic_seen.size(), 2);
        reset = 1;
        tick();
        reset = 0;
        chk("t6_mem_req", mem_rd_req, 0);
        wait_idle("t6");
        chk("t6_not_routed", ic_seen.size(), 2);
        chk("t6_perr", protocol_err, 0);
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_9000;
        tick();
        chk("t6_regrant", last_dc_rdy, 1);
        dc_rd_req = 0;
        wait_idle("t6b");

        // randomized traffic
        do_reset();
        br_gaps = 1; br_rand = 1; br_base = 32'h5500_0000;
        for (int c = 0; c < 1500; c++) begin
            if (!ic_rd_req && $urandom_range(0, 2) == 0) begin
                ic_rd_req  = 1;
                ic_rd_type = $urandom_range(0, 1) ? 3'b100 : 3'b010;
                ic_rd_addr = $urandom;
            end
            if (!dc_rd_req && $urandom_range(0, 2) == 0) begin
                dc_rd_req  = 1;
                dc_rd_type = $urandom_range(0, 1) ? 3'b100 : 3'b010;
                dc_rd_addr = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            end
            wb_busy = ($urandom_range(0, 3) == 0);
            wb_addr = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            tick();
            if (e_ic) ic_rd_req = 0;
            if (e_dc) dc_rd_req = 0;
        end
        ic_rd_req = 0; dc_rd_req = 0; wb_busy = 0;
        wait_idle("rand");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
